mem_port_arbiter: RTL

- Shares one single-ported synchronous BIOS/IMEM-style RAM between two requesters: the instruction-fetch stage (port I, read-only) and the memory stage (port D, read/write with byte mask).
- Grant decisions are combinational in the request cycle. Read responses are routed back one cycle later using a registered owner tag.
- A saturating starvation counter prevents the data port from locking out fetch indefinitely.
- Sits between the pipeline fetch/memory stages and the shared RAM. Requesters stall on `req & ~gnt`.

---
 rtl/mem_port_arbiter.sv | 75 +++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-ported sync RAM between fetch (I) and data (D) ports
// Data normally wins; a saturating starvation counter hands fetch the RAM after STARVE_LIMIT denials.
module mem_port_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic [3:0]        d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              fetch_starved
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DATA = 2'd2
  } owner_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  owner_t     owner;
  logic [3:0] starve_cnt;

  // Grants are forced low during reset so nothing reaches the RAM.
  assign fetch_starved = ~rst & (starve_cnt >= LIMIT);
  assign d_gnt         = ~rst & d_req & ~(i_req & fetch_starved);
  assign i_gnt         = ~rst & i_req & ~d_gnt;

  assign mem_en    = i_gnt | d_gnt;
  assign mem_we    = d_gnt ? d_we : 4'b0000;
  assign mem_addr  = d_gnt ? d_addr : i_addr;
  assign mem_wdata = d_wdata;

  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;
  assign i_rvalid = (owner == OWN_IF) & ~rst;
  assign d_rvalid = (owner == OWN_DATA) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      owner      <= OWN_NONE;
      starve_cnt <= 4'd0;
    end else begin
      if (d_gnt && d_we == 4'b0000)
        owner <= OWN_DATA;
      else if (i_gnt)
        owner <= OWN_IF;
      else
        owner <= OWN_NONE;

      // A dropped fetch request clears the counter rather than counting as starvation.
      if (i_req && !i_gnt)
        starve_cnt <= (starve_cnt >= LIMIT) ? LIMIT : starve_cnt + 4'd1;
      else
        starve_cnt <= 4'd0;
    end
  end

endmodule
